// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit seven-segment scan controller with frame-aligned load handshake
module seg_scan_ctrl #(
  parameter int CLK_DIV = 100000,
  parameter int GUARD   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic        load_ack,
  output logic [3:0]  nibble_out,
  output logic [3:0]  an,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] G_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] D_LAST = CW'(CLK_DIV - 1);

  typedef enum logic {S_GUARD, S_ON} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    digit, digit_nx;
  logic [15:0]   pend_data, pend_data_nx, shad_data, shad_data_nx;
  logic [3:0]    pend_dp, pend_dp_nx, shad_dp, shad_dp_nx;
  logic          pend_vld, pend_vld_nx;
  logic          boundary, ack_nx, blk;
  logic [3:0]    an_nx, nibble_nx;
  logic          dp_nx;

  always_comb begin
    state_nx = state;
    digit_nx = digit;
    cnt_nx   = cnt + CW'(1);
    if (state == S_GUARD) begin
      if (cnt == G_LAST) state_nx = S_ON;
    end else if (cnt == D_LAST) begin
      state_nx = S_GUARD;
      cnt_nx   = '0;
      digit_nx = digit + 2'd1;
    end

    boundary     = (digit == 2'd0) && (state == S_GUARD) && (cnt == '0);
    shad_data_nx = shad_data;
    shad_dp_nx   = shad_dp;
    pend_data_nx = pend_data;
    pend_dp_nx   = pend_dp;
    pend_vld_nx  = pend_vld;
    ack_nx       = 1'b0;
    // A load landing on the boundary itself bypasses the pending stage.
    if (boundary && load) begin
      shad_data_nx = data_in;
      shad_dp_nx   = dp_in;
      pend_data_nx = data_in;
      pend_dp_nx   = dp_in;
      pend_vld_nx  = 1'b0;
      ack_nx       = 1'b1;
    end else if (boundary && pend_vld) begin
      shad_data_nx = pend_data;
      shad_dp_nx   = pend_dp;
      pend_vld_nx  = 1'b0;
      ack_nx       = 1'b1;
    end else if (load) begin
      pend_data_nx = data_in;
      pend_dp_nx   = dp_in;
      pend_vld_nx  = 1'b1;
    end

    case (digit_nx)
      2'd1:    blk = blank_lz && (shad_data_nx[15:4] == 12'd0);
      2'd2:    blk = blank_lz && (shad_data_nx[15:8] == 8'd0);
      2'd3:    blk = blank_lz && (shad_data_nx[15:12] == 4'd0);
      default: blk = 1'b0;
    endcase

    nibble_nx = shad_data_nx[{digit_nx, 2'b00} +: 4];
    an_nx     = 4'b1111;
    dp_nx     = 1'b1;
    if (state_nx == S_ON && !blk) begin
      an_nx[digit_nx] = 1'b0;
      dp_nx           = ~shad_dp_nx[digit_nx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_GUARD;
      cnt        <= '0;
      digit      <= 2'd0;
      pend_data  <= 16'd0;
      pend_dp    <= 4'd0;
      pend_vld   <= 1'b0;
      shad_data  <= 16'd0;
      shad_dp    <= 4'd0;
      an         <= 4'b1111;
      dp_n       <= 1'b1;
      nibble_out <= 4'd0;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      digit      <= digit_nx;
      pend_data  <= pend_data_nx;
      pend_dp    <= pend_dp_nx;
      pend_vld   <= pend_vld_nx;
      shad_data  <= shad_data_nx;
      shad_dp    <= shad_dp_nx;
      an         <= an_nx;
      dp_n       <= dp_nx;
      nibble_out <= nibble_nx;
      load_ack   <= ack_nx;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl with a frame-arithmetic model
module tb_seg_scan_ctrl;

  localparam int CD = 8;
  localparam int GD = 2;
  localparam int FR = 4 * CD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = 16'd0;
  logic [3:0]  dp_in = 4'd0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        load_ack;
  logic [3:0]  nibble_out;
  logic [3:0]  an;
  logic        dp_n;
  logic        frame_tick;

  seg_scan_ctrl #(.CLK_DIV(CD), .GUARD(GD)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .load_ack(load_ack), .nibble_out(nibble_out), .an(an),
    .dp_n(dp_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: n is the index of the current cycle since reset release.
  bit          run = 1'b0;
  int          n = 0;
  logic [15:0] mshad, mpend;
  logic [3:0]  mdp, mpend_dp;
  bit          mpend_vld, mblank, exp_ack, exp_tick;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, n, act, exp);
    end
  endtask

  task automatic model_reset();
    mshad = 16'd0; mdp = 4'd0; mpend = 16'd0; mpend_dp = 4'd0;
    mpend_vld = 1'b0; exp_ack = 1'b0; exp_tick = 1'b0; mblank = blank_lz;
  endtask

  // End of cycle n: apply the handshake rules with frame boundaries every FR cycles.
  always @(posedge clk) begin
    if (run) begin
      exp_tick = (n % FR == 0);
      exp_ack  = 1'b0;
      if (exp_tick && load) begin
        mshad = data_in; mdp = dp_in; mpend_vld = 1'b0; exp_ack = 1'b1;
      end else if (exp_tick && mpend_vld) begin
        mshad = mpend; mdp = mpend_dp; mpend_vld = 1'b0; exp_ack = 1'b1;
      end else if (load) begin
        mpend = data_in; mpend_dp = dp_in; mpend_vld = 1'b1;
      end
      mblank = blank_lz;
      n++;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      int p, k, off;
      bit lit, blk;
      logic [3:0] an_e;
      logic [15:0] hi;
      p   = n % FR;
      k   = p / CD;
      off = p % CD;
      hi  = mshad >> (4 * k);
      blk = mblank && (k > 0) && (hi == 16'd0);
      lit = (off >= GD) && !blk;
      an_e = lit ? ~(4'b0001 << k) : 4'b1111;
      chk("an", an, an_e);
      chk("nibble_out", nibble_out, hi[3:0]);
      chk("dp_n", dp_n, lit ? !mdp[k] : 1);
      chk("frame_tick", frame_tick, exp_tick);
      chk("load_ack", load_ack, exp_ack);
    end
  end

  task automatic go_to(input int t);
    while (n < t) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    data_in = d; dp_in = p; load = 1'b1;
    go_to(n + 1);
    load = 1'b0;
  endtask

  task automatic pin(input int t, input logic [3:0] a, input logic [3:0] nb, input logic d);
    go_to(t);
    chk("pin_an", an, a);
    chk("pin_nibble", nibble_out, nb);
    chk("pin_dp_n", dp_n, d);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    model_reset();
    run = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_an", an, 4'b1111);
    chk("rst_nibble", nibble_out, 0);
    chk("rst_dp_n", dp_n, 1);
    release_reset();

    // Load in the very first (boundary) cycle bypasses into the shadow.
    do_load(16'h1234, 4'b0010);
    chk("first_tick", frame_tick, 1);
    chk("first_ack", load_ack, 1);
    pin(4,  4'b1110, 4'h4, 1'b1);
    pin(12, 4'b1101, 4'h3, 1'b0);
    pin(20, 4'b1011, 4'h2, 1'b1);
    pin(28, 4'b0111, 4'h1, 1'b1);
    pin(36, 4'b1110, 4'h4, 1'b1);

    // Mid-frame load during digit-2 ON.
    go_to(51);
    do_load(16'hABCD, 4'b0000);
    pin(52, 4'b1011, 4'h2, 1'b1);
    pin(60, 4'b0111, 4'h1, 1'b1);
    go_to(65);
    chk("midframe_ack", load_ack, 1);
    pin(68, 4'b1110, 4'hD, 1'b1);

    // Two loads within one frame: last one wins, single ack.
    go_to(70);
    do_load(16'h1111, 4'b0000);
    go_to(80);
    do_load(16'h2222, 4'b0000);
    go_to(97);
    chk("double_ack", load_ack, 1);
    pin(100, 4'b1110, 4'h2, 1'b1);

    // Leading-zero blanking on 0x0040.
    blank_lz = 1'b1;
    do_load(16'h0040, 4'b0000);
    pin(130, 4'b1110, 4'h0, 1'b1);
    pin(138, 4'b1101, 4'h4, 1'b1);
    go_to(146); chk("blank_d2_an", an, 4'b1111);
    go_to(154); chk("blank_d3_an", an, 4'b1111);
    go_to(160);
    blank_lz = 1'b0;
    pin(178, 4'b1011, 4'h0, 1'b1);
    pin(186, 4'b0111, 4'h0, 1'b1);

    // All-zero shadow with blanking: only digit 0 lights.
    blank_lz = 1'b1;
    do_load(16'h0000, 4'b1111);
    pin(194, 4'b1110, 4'h0, 1'b0);
    pin(202, 4'b1111, 4'h0, 1'b1);
    go_to(218); chk("zero_d3_an", an, 4'b1111);

    // Reset mid-ON with a pending load outstanding.
    go_to(225);
    do_load(16'h5555, 4'b1111);
    #1;
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    chk("midrst_an", an, 4'b1111);
    chk("midrst_nibble", nibble_out, 0);
    chk("midrst_dp_n", dp_n, 1);
    repeat (2) @(negedge clk);
    release_reset();
    go_to(1);
    chk("rerel_tick", frame_tick, 1);
    chk("rerel_ack", load_ack, 0);
    pin(4, 4'b1110, 4'h0, 1'b1);
    go_to(2 * FR + 4);

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
